dp_arbiter: RTL and testbench

- Shares the single drawing/memory datapath between NUM_REQ independent requester FSMs (ant draw, ant update, future game-logic blocks).
- Each requester port speaks the same start/instruction/finished/result protocol the datapath speaks, so requesters connect unchanged.
- The arbiter captures requests, grants round-robin, replays the 2-cycle start strobe to the datapath, and routes the result back to the owning port only.

---
 rtl/dp_arbiter_pkg.sv | 23 ++
 rtl/dp_rr_pick.sv | 31 +++
 rtl/dp_arbiter.sv | 148 ++++++++++++++
 tb/tb_dp_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_arbiter_pkg.sv
// dp_arbiter_pkg: shared widths, state encoding and helpers
// for the datapath arbiter slice.
package dp_arbiter_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int RESULT_WIDTH = 32;
  localparam int DPARB_TIMEOUT_CYCLES = 1023;

  typedef enum logic [1:0] {
    DPARB_IDLE  = 2'd0,
    DPARB_ISSUE = 2'd1,
    DPARB_HOLD  = 2'd2,
    DPARB_WAIT  = 2'd3
  } dparb_state_t;

  function automatic int dparb_next(
    input int idx,
    input int n
  );
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/dp_rr_pick.sv
// dp_rr_pick: combinational round-robin picker, first pending
// port at or after rr_ptr, wrapping modulo NUM_REQ.
module dp_rr_pick
  import dp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int idx;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = dparb_next(int'(rr_ptr) + k - 1, NUM_REQ);
      if (pending[IDX_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin share of the drawing datapath across
// NUM_REQ requesters. Optional WAIT watchdog: DPARB_TIMEOUT_EN.
module dp_arbiter
  import dp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int INSTR_W = INSTRUCTION_WIDTH,
  parameter int RES_W = RESULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DPARB_TIMEOUT_CYCLES
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_start,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  output logic [NUM_REQ-1:0]         req_finished,
  output logic [NUM_REQ*RES_W-1:0]   req_result,
  output logic                       dp_start,
  output logic [INSTR_W-1:0]         dp_instr,
  input  logic                       dp_finished,
  input  logic [RES_W-1:0]           dp_result,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  dparb_state_t state;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] start_q;
  logic [NUM_REQ-1:0] capture;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               seen_busy;
  logic               done_ok;
  logic               done_tmo;
  logic               complete;

  logic [INSTR_W-1:0] instr_buf [NUM_REQ];
  logic [RES_W-1:0]   result_q  [NUM_REQ];

  dp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Rising edge on an idle port only; busy ports drop new edges.
  assign capture = req_start & ~start_q & req_finished;

  assign done_ok = (state == DPARB_WAIT)
                 && dp_finished && seen_busy;
  assign complete = done_ok | done_tmo;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_res
    assign req_result[i*RES_W +: RES_W] = result_q[i];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= DPARB_IDLE;
      pending <= '0;
      start_q <= '0;
      rr_ptr <= '0;
      grant_q <= '0;
      seen_busy <= 1'b0;
      req_finished <= '1;
      dp_start <= 1'b0;
      dp_instr <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        instr_buf[i] <= '0;
        result_q[i] <= '0;
      end
    end else begin
      start_q <= req_start;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) begin
          instr_buf[i] <= req_instr[i*INSTR_W +: INSTR_W];
          pending[i] <= 1'b1;
          req_finished[i] <= 1'b0;
        end
      end
      unique case (state)
        DPARB_IDLE: begin
          if (grant_valid && dp_finished) begin
            grant_q <= grant_idx;
            dp_start <= 1'b1;
            dp_instr <= instr_buf[grant_idx];
            seen_busy <= 1'b0;
            state <= DPARB_ISSUE;
          end
        end
        DPARB_ISSUE: begin
          state <= DPARB_HOLD;
        end
        DPARB_HOLD: begin
          dp_start <= 1'b0;
          state <= DPARB_WAIT;
        end
        DPARB_WAIT: begin
          if (!dp_finished) seen_busy <= 1'b1;
          if (complete) begin
            result_q[grant_q] <= done_ok ? dp_result : '0;
            pending[grant_q] <= 1'b0;
            req_finished[grant_q] <= 1'b1;
            rr_ptr <= IDX_W'(dparb_next(int'(grant_q), NUM_REQ));
            state <= DPARB_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DPARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign done_tmo = (state == DPARB_WAIT)
                  && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == DPARB_WAIT && !complete)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (done_tmo && !done_ok)
        timeout_err <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign done_tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: randomized bench for dp_arbiter with a
// behavioural datapath and a round-robin service-order model.
module tb_dp_arbiter;

  localparam int N = 4;
  localparam int IW = 32;
  localparam int RW = 32;
`ifdef DPARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1023;
`endif

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req_start = '0;
  logic [N*IW-1:0] req_instr = '0;
  logic [N-1:0]    req_finished;
  logic [N*RW-1:0] req_result;
  logic            dp_start;
  logic [IW-1:0]   dp_instr;
  logic            dp_finished;
  logic [RW-1:0]   dp_result;
  logic            timeout_err;

  int vectors = 0;
  int miscompares = 0;

  bit hang = 0;
  int fixed_lat = 0;
  bit dp_waiting = 0;
  int start_hi = 0;

  logic [31:0] log_instr[$];
  int          log_width[$];
  bit          log_stable[$];

  logic [31:0] inst_m [N];
  logic [31:0] res_m  [N];
  int          ptr_m = 0;

  dp_arbiter #(
    .NUM_REQ        (N),
    .INSTR_W        (IW),
    .RES_W          (RW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_start    (req_start),
    .req_instr    (req_instr),
    .req_finished (req_finished),
    .req_result   (req_result),
    .dp_start     (dp_start),
    .dp_instr     (dp_instr),
    .dp_finished  (dp_finished),
    .dp_result    (dp_result),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dp_func(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] res_of(input int p);
    return req_result[p*RW +: RW];
  endfunction

  // Behavioural datapath: busy after the start strobe, done later.
  initial begin
    logic [31:0] cur;
    int w;
    bit st;
    int lat;
    dp_finished = 1'b1;
    dp_result = '0;
    forever begin
      @(negedge clock);
      if (dp_start === 1'b1) begin
        cur = dp_instr;
        w = 1;
        st = 1;
        @(negedge clock);
        while (dp_start === 1'b1 && w < 10) begin
          w++;
          if (dp_instr !== cur) st = 0;
          @(negedge clock);
        end
        dp_finished = 1'b0;
        dp_waiting = 1;
        while (hang) @(negedge clock);
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
        repeat (lat) @(negedge clock);
        dp_result = dp_func(cur);
        dp_finished = 1'b1;
        dp_waiting = 0;
        log_instr.push_back(cur);
        log_width.push_back(w);
        log_stable.push_back(st);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (dp_start === 1'b1) start_hi++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic set_instr(input int p, input logic [31:0] v);
    req_instr[p*IW +: IW] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    req_start = '0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    ptr_m = 0;
    for (int p = 0; p < N; p++) res_m[p] = '0;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    @(negedge clock);
    req_start = mask;
    @(negedge clock);
    req_start = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (&req_finished && dp_finished) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (req_finished !== '1) begin
      miscompares++;
      $display("FAIL rst_fin: got %b want 1111", req_finished);
    end
    vectors++;
    if (req_result !== '0) begin
      miscompares++;
      $display("FAIL rst_res: got %h want 0", req_result);
    end
    vectors++;
    if (dp_start !== 1'b0 || dp_instr !== '0) begin
      miscompares++;
      $display("FAIL rst_dp: got %b/%h want 0/0",
               dp_start, dp_instr);
    end
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_tmo: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_single();
    int base;
    bit ok;
    do_reset();
    fixed_lat = 3;
    inst_m[1] = 32'h0000_0ABC;
    set_instr(1, inst_m[1]);
    base = log_instr.size();
    pulse(4'b0010);
    vectors++;
    if (req_finished !== 4'b1101) begin
      miscompares++;
      $display("FAIL single_busy: got %b want 1101", req_finished);
    end
    wait_idle(100, ok);
    fixed_lat = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_done: got busy want idle");
    end
    vectors++;
    if (log_instr.size() != base + 1
        || log_instr[base] !== 32'h0000_0ABC
        || log_width[base] != 2 || !log_stable[base]) begin
      miscompares++;
      $display("FAIL single_issue: got n=%0d want one 2-cycle 0abc",
               log_instr.size() - base);
    end
    vectors++;
    if (res_of(1) !== dp_func(32'h0000_0ABC)) begin
      miscompares++;
      $display("FAIL single_res: got %h want %h",
               res_of(1), dp_func(32'h0000_0ABC));
    end
    vectors++;
    if (res_of(0) !== '0 || res_of(2) !== '0 || res_of(3) !== '0) begin
      miscompares++;
      $display("FAIL single_other: got %h want others 0", req_result);
    end
    vectors++;
    if (dp_instr !== 32'h0000_0ABC) begin
      miscompares++;
      $display("FAIL single_hold: got %h want 00000abc", dp_instr);
    end
    res_m[1] = dp_func(32'h0000_0ABC);
    ptr_m = 2;
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input string name);
    int base;
    int order[$];
    bit pm[N];
    bit ok;
    int g;
    for (int p = 0; p < N; p++) begin
      pm[p] = mask[p];
      if (mask[p]) begin
        inst_m[p] = ($urandom & 32'h0FFF_FFFF) | (p << 28);
        set_instr(p, inst_m[p]);
      end
    end
    while (pm.or() != 0) begin
      for (int k = 0; k < N; k++) begin
        g = (ptr_m + k) % N;
        if (pm[g]) begin
          order.push_back(g);
          pm[g] = 0;
          ptr_m = (g + 1) % N;
          break;
        end
      end
    end
    base = log_instr.size();
    pulse(mask);
    wait_idle(400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_done: got busy want idle", name);
    end
    vectors++;
    if (log_instr.size() - base != order.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d want %0d", name,
               log_instr.size() - base, order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      if (base + k < log_instr.size()) begin
        vectors++;
        if (log_instr[base+k] !== inst_m[order[k]]
            || log_width[base+k] != 2 || !log_stable[base+k]) begin
          miscompares++;
          $display("FAIL %s_order%0d: got %h w%0d want %h (port %0d)",
                   name, k, log_instr[base+k], log_width[base+k],
                   inst_m[order[k]], order[k]);
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (mask[p]) res_m[p] = dp_func(inst_m[p]);
      vectors++;
      if (res_of(p) !== res_m[p]) begin
        miscompares++;
        $display("FAIL %s_res%0d: got %h want %h",
                 name, p, res_of(p), res_m[p]);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    run_batch(4'b1101, "cont_a");
    run_batch(4'b1001, "cont_b");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_batch(N'($urandom_range(1, 15)), "rand");
    end
  endtask

  task automatic test_fairness();
    int cnt[2];
    logic [31:0] fq[2][$];
    logic [31:0] v;
    int base;
    bit done;
    do_reset();
    cnt[0] = 0;
    cnt[1] = 0;
    done = 0;
    base = log_instr.size();
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        if (req_start[p]) begin
          req_start[p] = 1'b0;
        end else if (req_finished[p] && cnt[p] < 3) begin
          v = $urandom;
          set_instr(p, v);
          fq[p].push_back(v);
          req_start[p] = 1'b1;
          cnt[p]++;
        end
      end
      if (cnt[0] == 3 && cnt[1] == 3 && req_start == '0
          && &req_finished)
        done = 1;
    end
    vectors++;
    if (!done || log_instr.size() - base != 6) begin
      miscompares++;
      $display("FAIL fair_done: got %0d ops want 6",
               log_instr.size() - base);
    end
    for (int k = 0; k < 6; k++) begin
      if (base + k < log_instr.size() && k / 2 < fq[k%2].size()) begin
        vectors++;
        if (log_instr[base+k] !== fq[k%2][k/2]) begin
          miscompares++;
          $display("FAIL fair_grant%0d: got %h want %h (port %0d)",
                   k, log_instr[base+k], fq[k%2][k/2], k % 2);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fq[p].size() > 0) begin
        res_m[p] = dp_func(fq[p][fq[p].size()-1]);
        vectors++;
        if (res_of(p) !== res_m[p]) begin
          miscompares++;
          $display("FAIL fair_res%0d: got %h want %h",
                   p, res_of(p), res_m[p]);
        end
      end
    end
    ptr_m = 0;
  endtask

  task automatic test_held_start();
    int base;
    bit ok;
    inst_m[2] = $urandom;
    set_instr(2, inst_m[2]);
    base = log_instr.size();
    @(negedge clock);
    req_start[2] = 1'b1;
    repeat (20) @(negedge clock);
    req_start[2] = 1'b0;
    wait_idle(100, ok);
    vectors++;
    if (!ok || log_instr.size() != base + 1) begin
      miscompares++;
      $display("FAIL held_ops: got %0d want 1", log_instr.size() - base);
    end
    vectors++;
    if (res_of(2) !== dp_func(inst_m[2])) begin
      miscompares++;
      $display("FAIL held_res: got %h want %h",
               res_of(2), dp_func(inst_m[2]));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int s;
    hang = 1;
    inst_m[3] = $urandom;
    set_instr(3, inst_m[3]);
    pulse(4'b1000);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (dp_waiting) ok = 1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rmw_wait: got no busy want busy");
    end
    do_reset();
    vectors++;
    if (req_finished !== '1 || dp_start !== 1'b0
        || req_result !== '0) begin
      miscompares++;
      $display("FAIL rmw_rst: got fin=%b start=%b want 1111/0",
               req_finished, dp_start);
    end
    inst_m[1] = $urandom;
    set_instr(1, inst_m[1]);
    s = start_hi;
    pulse(4'b0010);
    repeat (10) @(negedge clock);
    vectors++;
    if (start_hi != s || req_finished !== 4'b1101) begin
      miscompares++;
      $display("FAIL rmw_block: got starts=%0d fin=%b want 0/1101",
               start_hi - s, req_finished);
    end
    hang = 0;
    wait_idle(100, ok);
    vectors++;
    if (!ok || res_of(1) !== dp_func(inst_m[1])) begin
      miscompares++;
      $display("FAIL rmw_res1: got %h want %h",
               res_of(1), dp_func(inst_m[1]));
    end
    vectors++;
    if (res_of(3) !== '0) begin
      miscompares++;
      $display("FAIL rmw_res3: got %h want 0", res_of(3));
    end
  endtask

`ifdef DPARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int waited;
    do_reset();
    hang = 1;
    set_instr(0, 32'hDEAD_BEEF);
    pulse(4'b0001);
    ok = 0;
    waited = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      waited++;
      if (req_finished[0]) ok = 1;
    end
    vectors++;
    if (!ok || res_of(0) !== '0) begin
      miscompares++;
      $display("FAIL tmo_done: got fin=%b res=%h want 1/0",
               req_finished[0], res_of(0));
    end
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_flag: got %b want 1", timeout_err);
    end
    hang = 0;
    repeat (15) @(negedge clock);
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_sticky: got %b want 1", timeout_err);
    end
  endtask
`else
  task automatic test_timeout();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_tied: got %b want 0", timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_random();
    test_fairness();
    test_held_start();
    test_reset_mid_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
